// File: rtl/riscv_soft_fetch_queue_if.sv
// Handshake bundle between the riscv_soft fetch queue, the instruction cache and EX.
// The master modport is the fetch queue side; slave is the cache/EX environment.
interface riscv_soft_fetch_queue_if #(
  parameter int XPR_LEN = 32
);
  logic               redirect_valid;
  logic [XPR_LEN-1:0] redirect_pc;
  logic               i_cache_req_ready;
  logic               i_cache_req_valid;
  logic [XPR_LEN-1:0] i_cache_req_addr;
  logic               i_cache_resp_valid;
  logic [31:0]        i_cache_resp_data;
  logic               inst_valid;
  logic [31:0]        inst_data;
  logic [XPR_LEN-1:0] inst_pc;
  logic               inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, i_cache_req_ready,
    input  i_cache_resp_valid, i_cache_resp_data, inst_ready,
    output i_cache_req_valid, i_cache_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, i_cache_req_ready,
    output i_cache_resp_valid, i_cache_resp_data, inst_ready,
    input  i_cache_req_valid, i_cache_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface

// File: rtl/riscv_soft_fetch_queue.sv
// Sequential instruction fetch front end: credit-limited cache requests, in-order
// responses buffered with their PCs, redirect flush with stale-response dropping.
module riscv_soft_fetch_queue #(
  parameter int                 XPR_LEN     = 32,
  parameter int                 QUEUE_DEPTH = 4,
  parameter logic [XPR_LEN-1:0] RESET_PC    = {XPR_LEN{1'b0}}
) (
  input logic                      clk,
  input logic                      reset,
  riscv_soft_fetch_queue_if.master fq
);
  localparam int                 PW         = $clog2(QUEUE_DEPTH);
  localparam int                 CW         = PW + 1;
  localparam logic [CW:0]        DEPTH_C    = (CW+1)'(QUEUE_DEPTH);
  localparam logic [CW-1:0]      CNT_ZERO   = {CW{1'b0}};
  localparam logic [PW-1:0]      PTR_ZERO   = {PW{1'b0}};
  localparam logic [XPR_LEN-1:0] PC_STEP    = XPR_LEN'(3'd4);
  localparam logic [XPR_LEN-1:0] ALIGN_MASK = ~(XPR_LEN'(2'd3));

  logic [XPR_LEN-1:0] fetch_pc_r;
  logic [XPR_LEN-1:0] resp_pc_r;
  logic [XPR_LEN-1:0] q_pc_r   [QUEUE_DEPTH];
  logic [31:0]        q_data_r [QUEUE_DEPTH];
  logic [PW-1:0]      rd_ptr_r;
  logic [PW-1:0]      wr_ptr_r;
  logic [CW-1:0]      count_r;
  logic [CW-1:0]      out_r;
  logic [CW-1:0]      drop_r;

  logic [CW:0]        credit_sum_s;
  logic               resp_s;
  logic               req_valid_s;
  logic               fire_s;
  logic               push_s;
  logic               inst_valid_s;
  logic               pop_s;

  // Handshake qualifiers; a response with nothing outstanding belongs to a request
  // issued before reset and is ignored.
  always_comb begin
    resp_s       = fq.i_cache_resp_valid && (out_r != CNT_ZERO);
    credit_sum_s = {1'b0, out_r} + {1'b0, count_r};
    req_valid_s  = !fq.redirect_valid && (credit_sum_s < DEPTH_C);
    fire_s       = req_valid_s && fq.i_cache_req_ready;
    push_s       = resp_s && !fq.redirect_valid && (drop_r == CNT_ZERO);
    inst_valid_s = (count_r != CNT_ZERO) && !fq.redirect_valid;
    pop_s        = inst_valid_s && fq.inst_ready;
  end

  assign fq.i_cache_req_valid = req_valid_s;
  assign fq.i_cache_req_addr  = fetch_pc_r;
  assign fq.inst_valid        = inst_valid_s;
  assign fq.inst_data         = q_data_r[rd_ptr_r];
  assign fq.inst_pc           = q_pc_r[rd_ptr_r];

  // Queue storage; entries are meaningful only while counted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_pc_r[wr_ptr_r]   <= resp_pc_r;
      q_data_r[wr_ptr_r] <= fq.i_cache_resp_data;
    end
  end

  // Fetch/response PCs, pointers and credit counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_r <= RESET_PC & ALIGN_MASK;
      resp_pc_r  <= RESET_PC & ALIGN_MASK;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      out_r      <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
    end else if (fq.redirect_valid) begin
      // Everything still in flight after this cycle is stale and must be dropped.
      fetch_pc_r <= fq.redirect_pc & ALIGN_MASK;
      resp_pc_r  <= fq.redirect_pc & ALIGN_MASK;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      out_r      <= out_r - CW'(resp_s);
      drop_r     <= out_r - CW'(resp_s);
    end else begin
      if (fire_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end
      out_r <= out_r + CW'(fire_s) - CW'(resp_s);
      if (resp_s && (drop_r != CNT_ZERO)) begin
        drop_r <= drop_r - CW'(1'b1);
      end
      if (push_s) begin
        wr_ptr_r  <= wr_ptr_r + PW'(1'b1);
        resp_pc_r <= resp_pc_r + PC_STEP;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end
endmodule

// File: doc/riscv_soft_fetch_queue.md
# riscv_soft_fetch_queue

Parametrised instruction-fetch front end for the riscv_soft core. It generates sequential fetch addresses toward the instruction cache over a valid/ready request channel and accepts in-order responses of arbitrary latency. Fetched words are buffered with their PCs in a QUEUE_DEPTH-entry queue that feeds the EX stage over a valid/ready interface. A redirect flushes the queue, discards in-flight responses and restarts fetch at a new PC.

## Interface
- XPR_LEN, 32, address/PC width
- QUEUE_DEPTH, 4, instruction queue entries; power of two, >= 2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; clears all state while 0
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XPR_LEN  new fetch PC; bits [1:0] ignored (treated as 0)
- i_cache_req_ready  in  1  cache accepts request
- i_cache_req_valid  out  1  fetch request valid
- i_cache_req_addr  out  XPR_LEN  fetch address, word aligned
- i_cache_resp_valid  in  1  response word valid; one per accepted request, in order, >= 1 cycle after acceptance
- i_cache_resp_data  in  32  instruction word
- inst_valid  out  1  inst_data/inst_pc valid
- inst_data  out  32  instruction at queue head
- inst_pc  out  XPR_LEN  PC of inst_data
- inst_ready  in  1  consumer accepts head entry

## Operation
- State: fetch_pc, resp_pc, queue (DEPTH x {pc, data}), rd_ptr, wr_ptr, count, outstanding, drop_cnt. Counters are clog2(QUEUE_DEPTH)+1 bits wide.
- Reset (reset=0 at an edge): fetch_pc = resp_pc = RESET_PC with [1:0] cleared; count = outstanding = drop_cnt = 0; pointers 0.
- Request: i_cache_req_valid = !redirect_valid && (outstanding + count < QUEUE_DEPTH). i_cache_req_addr = fetch_pc.
  - req_fire = valid && ready; fetch_pc += 4 (mod 2^XPR_LEN); outstanding += 1.
  - Once valid is asserted, addr is held stable until fire or redirect.
- Response: every resp_valid decrements outstanding.
  - If drop_cnt > 0 or redirect_valid: word discarded; drop_cnt -= 1 when drop_cnt > 0.
  - Otherwise: queue[wr_ptr] = {resp_pc, data}; wr_ptr += 1 (mod DEPTH); resp_pc += 4.
  - The credit rule guarantees a push never finds the queue full.
- Output: inst_valid = (count != 0) && !redirect_valid; inst_data/inst_pc = queue[rd_ptr]. pop = inst_valid && inst_ready; on pop, rd_ptr += 1 (mod DEPTH).
- count next = count + push - pop. Simultaneous push and pop leave count unchanged.
- Redirect (redirect_valid=1, overrides all else this cycle):
  - fetch_pc = resp_pc = redirect_pc & ~3.
  - count = 0, rd_ptr = wr_ptr = 0.
  - drop_cnt = outstanding - resp_valid; outstanding = outstanding - resp_valid.
  - No request issued; no pop counted.
- Back-to-back redirects: each recomputes drop_cnt from current outstanding; only the last target is fetched.
- Cache stalls (req_ready=0) hold fetch_pc and addr. Responses are never back-pressured.

## Timing
- Reset outputs: i_cache_req_valid = 1 on the first cycle with reset=1, at addr RESET_PC (queue empty, credits available). inst_valid = 0. inst_data/inst_pc are don't-care while inst_valid=0.
- Request accepted at cycle T -> earliest response T+1 -> inst_valid at T+2 (queue registered; no resp-to-output bypass).
- Steady-state throughput: one instruction per cycle when the cache returns one response per cycle and the queue is not full.
- Redirect at cycle R:
  - inst_valid = 0 and req_valid = 0 during R.
  - First request at redirect_pc at R+1 if credits allow.
  - Pre-redirect responses arriving after R are silently dropped.
- Credit stall: when outstanding + count = QUEUE_DEPTH, req_valid drops the same cycle (combinational from registered state). It reasserts the cycle after a pop or a response is freed by redirect.

## Test plan
- Reset release, cache always ready, fixed 1-cycle response latency, inst_ready=1 -> addrs 0,4,8,... one per cycle; inst_pc 0 first seen 2 cycles after first fire; inst_data matches the model word for each PC.
- inst_ready=0 with DEPTH=4 -> exactly 4 requests issued, req_valid then held 0; count=4; raising inst_ready pops PCs 0,4,8,12 in order and fetch resumes at 16.
- Redirect to 0x103 with 2 responses outstanding (latency 3) -> next request addr 0x100; both stale responses dropped; first inst_pc after redirect = 0x100.
- Redirect in the same cycle a response arrives, plus a second redirect one cycle later to 0x200 -> no stale word or 0x100-stream word emitted; first inst_pc = 0x200.
- Random req_ready/resp latency/inst_ready for 10k cycles with DEPTH=2 and DEPTH=8 -> instruction stream equals the golden sequential PC stream; outstanding + count never exceeds DEPTH.
- reset asserted mid-stream with count=3 and 2 outstanding -> next cycle inst_valid=0, addr RESET_PC; late responses before the first new fire are ignored (model treats the cache as also reset).
